// File: rtl/conv_table_writer.sv
// conv_table_writer: run-time filler for the 282-entry temperature conversion RAM.
//   addr 0..C_LAST          : Celsius->Fahrenheit, C = addr, value = round(9C/5)+32
//   addr C_LAST+1..LAST_ADDR: Fahrenheit->Celsius, F = addr - F_OFFSET, value = round(5(F-32)/9)
// Each entry takes one SETUP cycle, ten restoring-divide cycles and one WRITE
// cycle (longer if the RAM stalls the write with wr_ready low).
// Optional build macro: CONV_CHECKSUM_EN adds a 16-bit running sum of all
// written bytes on the checksum output.
module conv_table_writer #(
  parameter int unsigned C_LAST    = 100,
  parameter int unsigned F_OFFSET  = 69,
  parameter int unsigned LAST_ADDR = 281
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [7:0]  wr_data,
`ifdef CONV_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DIV   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [8:0] C_LAST_A = 9'(C_LAST);
  localparam logic [8:0] LAST_A   = 9'(LAST_ADDR);
  // F->C numerators are built from (addr - F_OFFSET - 32) = F - 32.
  localparam logic [9:0] F_BASE   = 10'(F_OFFSET + 32);

  state_e      state_q, state_d;
  logic [8:0]  addr_q, addr_d;
  logic [9:0]  num_q, num_d;     // numerator, becomes quotient after 10 shifts
  logic [3:0]  rem_q, rem_d;     // partial remainder, always < divisor (<= 9)
  logic [3:0]  div_q, div_d;     // divisor: 5 or 9
  logic [3:0]  cnt_q, cnt_d;     // divide step counter 0..9
  logic        is_c_q, is_c_d;   // current entry is C->F (adds 32 to quotient)
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef CONV_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  // Datapath helpers: numerator setup and one restoring-divide step.
  logic [9:0]  addr_ext_s;
  logic [9:0]  n_cf_s;
  logic [9:0]  f_rel_s;
  logic [9:0]  n_fc_s;
  logic [4:0]  trial_s;
  logic        qbit_s;
  logic [3:0]  rem_next_s;
  logic [9:0]  num_next_s;
  logic [9:0]  res10_s;
  logic [7:0]  result_s;

  // Combinational numerator setup and single divide step.
  always_comb begin
    addr_ext_s = {1'b0, addr_q};
    // 9*C + 2: the +2 (= D/2 rounded down) turns floor division into round-to-nearest.
    n_cf_s     = (addr_ext_s << 3) + addr_ext_s + 10'd2;
    f_rel_s    = addr_ext_s - F_BASE;
    // 5*(F-32) + 4: likewise rounds, since neither table hits an exact .5.
    n_fc_s     = (f_rel_s << 2) + f_rel_s + 10'd4;

    trial_s = {rem_q, num_q[9]};
    if (trial_s >= {1'b0, div_q}) begin
      qbit_s     = 1'b1;
      // True difference is < divisor, so a 4-bit subtraction is exact.
      rem_next_s = trial_s[3:0] - div_q;
    end else begin
      qbit_s     = 1'b0;
      rem_next_s = trial_s[3:0];
    end
    num_next_s = {num_q[8:0], qbit_s};

    if (is_c_q) begin
      res10_s = num_next_s + 10'd32;
    end else begin
      res10_s = num_next_s;
    end
    // Results are at most 212; saturate rather than wrap if that ever breaks.
    if (res10_s > 10'd255) begin
      result_s = 8'hFF;
    end else begin
      result_s = res10_s[7:0];
    end
  end

  // Next-state and next-output logic of the fill sequencer.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    num_d     = num_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    is_c_d    = is_c_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef CONV_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETUP;
          addr_d  = 9'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef CONV_CHECKSUM_EN
          csum_d  = 16'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end

      S_SETUP: begin
        rem_d   = 4'd0;
        cnt_d   = 4'd0;
        state_d = S_DIV;
        if (addr_q <= C_LAST_A) begin
          num_d  = n_cf_s;
          div_d  = 4'd5;
          is_c_d = 1'b1;
        end else begin
          num_d  = n_fc_s;
          div_d  = 4'd9;
          is_c_d = 1'b0;
        end
      end

      S_DIV: begin
        num_d = num_next_s;
        rem_d = rem_next_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_data_d = result_s;
        end else begin
          state_d   = S_DIV;
        end
      end

      S_WRITE: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
`ifdef CONV_CHECKSUM_EN
          csum_d  = csum_q + {8'd0, wr_data_q};
`endif
          if (addr_q == LAST_A) begin
            // Counter parks at the last address; start is not sampled here.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            addr_d  = addr_q + 9'd1;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any fill in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= 9'd0;
      num_q     <= 10'd0;
      rem_q     <= 4'd0;
      div_q     <= 4'd0;
      cnt_q     <= 4'd0;
      is_c_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CONV_CHECKSUM_EN
      csum_q    <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      is_c_q    <= is_c_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CONV_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef CONV_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_conv_table_writer.sv
// Directed bench for conv_table_writer: reset values, full fills against an
// independent rounding model, write stall, mid-fill reset, start while busy
// and restart after done. Checksum checks are built with CONV_CHECKSUM_EN.
module tb_conv_table_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        wr_ready;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
`ifdef CONV_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  conv_table_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef CONV_CHECKSUM_EN
    .checksum (checksum),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Write log filled by the monitor, cleared on request from the stimulus.
  logic       clr_log = 1'b0;
  logic       hs;
  logic       prev_hs = 1'b0;
  int         wr_cnt [0:281];
  logic [7:0] wr_val [0:281];
  int         wr_total  = 0;
  int         order_err = 0;
  int         oob       = 0;
  int         b2b_err   = 0;
  int         last_seen = -1;
  int         cyc       = 0;

  assign hs = rst_n & wr_en & wr_ready;

  // Handshake monitor and free-running cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_log) begin
      for (int i = 0; i < 282; i++) begin
        wr_cnt[i] <= 0;
        wr_val[i] <= 8'd0;
      end
      wr_total  <= 0;
      order_err <= 0;
      oob       <= 0;
      b2b_err   <= 0;
      last_seen <= -1;
      prev_hs   <= 1'b0;
    end else begin
      prev_hs <= hs;
      if (prev_hs && wr_en) b2b_err <= b2b_err + 1;
      if (hs) begin
        wr_total  <= wr_total + 1;
        last_seen <= int'(wr_addr);
        if (int'(wr_addr) != last_seen + 1) order_err <= order_err + 1;
        if (wr_addr > 9'd281) begin
          oob <= oob + 1;
        end else begin
          wr_cnt[wr_addr] <= wr_cnt[wr_addr] + 1;
          wr_val[wr_addr] <= wr_data;
        end
      end
    end
  end

  // Reference: round(9C/5)+32 and round(5(F-32)/9) via doubled-denominator rounding.
  function automatic int model(input int a);
    int f;
    f = a - 69;
    if (a <= 100) return (18 * a + 5) / 10 + 32;
    else          return (10 * (f - 32) + 9) / 18;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk); clr_log = 1'b1;
    @(negedge clk); clr_log = 1'b0;
  endtask

  // One-cycle start pulse; t0 is the cycle stamp of the sampling edge.
  task automatic pulse_start(output int t0);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_addr(input logic [8:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (wr_addr !== target && n < budget) begin
      @(negedge clk); n++;
    end
    chk(tag, int'(wr_addr === target), 1);
  endtask

  task automatic run_to_done(input int t0, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 5000) begin
      @(negedge clk); n++;
    end
    chk(tag, cyc - t0, 3384);
  endtask

  task automatic check_fill(input string tag);
    int bad_val;
    int bad_cnt;
    bad_val = 0;
    bad_cnt = 0;
    for (int a = 0; a < 282; a++) begin
      if (int'(wr_val[a]) != model(a)) bad_val++;
      if (wr_cnt[a] != 1) bad_cnt++;
    end
    chk({tag, "_values"}, bad_val, 0);
    chk({tag, "_once"}, bad_cnt, 0);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_total"}, wr_total, 282);
    chk({tag, "_b2b"}, b2b_err, 0);
    chk({tag, "_oob"}, oob, 0);
  endtask

  int t0;
  int stall_bad;
  int sum_model;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    wr_ready = 1'b1;
    sum_model = 0;
    for (int a = 0; a < 282; a++) sum_model = (sum_model + model(a)) % 65536;

    // Reset values.
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    clear_log();

    // Fill 1: wr_ready tied high.
    pulse_start(t0);
    chk("f1_busy", int'(busy), 1);
    run_to_done(t0, "f1_latency");
    chk("f1_busy_end", int'(busy), 0);
    chk("f1_a0", int'(wr_val[0]), 32);
    chk("f1_a37", int'(wr_val[37]), 99);
    chk("f1_a100", int'(wr_val[100]), 212);
    chk("f1_a101", int'(wr_val[101]), 0);
    chk("f1_a170", int'(wr_val[170]), 38);
    chk("f1_a281", int'(wr_val[281]), 100);
    check_fill("f1");
`ifdef CONV_CHECKSUM_EN
    chk("f1_checksum", int'(checksum), sum_model);
`endif
    repeat (5) @(negedge clk);
    chk("f1_done_held", int'(done), 1);
    chk("f1_idle_wr_en", int'(wr_en), 0);

    // Fill 2: restart after done, stall the write at addr 101.
    clear_log();
    pulse_start(t0);
    chk("f2_done_drop", int'(done), 0);
    chk("f2_busy", int'(busy), 1);
`ifdef CONV_CHECKSUM_EN
    chk("f2_checksum_clr", int'(checksum), 0);
`endif
    wait_addr(9'd101, 2000, "f2_reach101");
    wr_ready = 1'b0;
    for (int n = 0; n < 20 && wr_en !== 1'b1; n++) @(negedge clk);
    chk("f2_wr_en_up", int'(wr_en), 1);
    stall_bad = 0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (wr_en !== 1'b1 || wr_addr !== 9'd101 || wr_data !== 8'd0) stall_bad++;
    end
    chk("f2_stall_stable", stall_bad, 0);
    chk("f2_no_write_in_stall", wr_cnt[101], 0);
    wr_ready = 1'b1;
    @(negedge clk);
    chk("f2_one_write", wr_cnt[101], 1);
    chk("f2_wr_en_drop", int'(wr_en), 0);
    for (int n = 0; n < 5000 && done !== 1'b1; n++) @(negedge clk);
    chk("f2_done", int'(done), 1);
    check_fill("f2");
`ifdef CONV_CHECKSUM_EN
    chk("f2_checksum", int'(checksum), sum_model);
`endif

    // Fill 3: start pulsed while busy at addr 10 is ignored.
    clear_log();
    pulse_start(t0);
    wait_addr(9'd10, 500, "f3_reach10");
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    run_to_done(t0, "f3_latency");
    check_fill("f3");

    // Fill 4: asynchronous reset during DIV at addr 50.
    clear_log();
    pulse_start(t0);
    wait_addr(9'd50, 1000, "f4_reach50");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_wr_data", int'(wr_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
`ifdef CONV_CHECKSUM_EN
    chk("mid_rst_checksum", int'(checksum), 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("f4_writes_before_rst", wr_total, 50);
    chk("f4_no_write50", wr_cnt[50], 0);
    chk("f4_idle_busy", int'(busy), 0);

    // Fill 5: refill from addr 0 after the reset.
    clear_log();
    pulse_start(t0);
    run_to_done(t0, "f5_latency");
    check_fill("f5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
